pid_pwm_driver: RTL and testbench

- Converts signed per-channel PID controller outputs (motor speed commands in RPM units) into PWM drive for NUM_CHN H-bridge motor channels.
- Sits between the PID channel-multiplexed output stream and the motor driver pins.
- Sign of the command selects direction (which H-bridge input is pulsed); magnitude, saturated at RPM_MAX, sets the duty cycle.

---
 rtl/pid_pwm_driver.sv | 121 ++++++++++++
 tb/tb_pid_pwm_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_driver.sv
// Turns signed per-channel PID speed commands into direction-aware PWM for four H-bridges.
// Commands are double-buffered so the duty cycle only changes at a PWM period boundary.
module pid_pwm_driver #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN    = 4,
  localparam int CHN_WIDTH = 3,
  parameter int RPM_MAX    = 1500,
  parameter int CLK_FREQ   = 27_000_000,
  parameter int PWM_FREQ   = 100_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clk_pwm,
  input  logic                  u_valid_o,
  input  logic [CHN_WIDTH-1:0]  u_chn_o,
  input  logic [DATA_WIDTH-1:0] u_data_o,
  output logic                  motor_0_in_1,
  output logic                  motor_0_in_2,
  output logic                  motor_1_in_1,
  output logic                  motor_1_in_2,
  output logic                  motor_2_in_1,
  output logic                  motor_2_in_2,
  output logic                  motor_3_in_1,
  output logic                  motor_3_in_2
);

  localparam int PWM_PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int CNT_W      = $clog2(PWM_PERIOD);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(PWM_PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] RPM_MAX_W = DATA_WIDTH'(RPM_MAX);

  logic [DATA_WIDTH-1:0] pending      [NUM_CHN];
  logic [DATA_WIDTH-1:0] pending_next [NUM_CHN];
  logic [DATA_WIDTH-1:0] active       [NUM_CHN];
  logic [DATA_WIDTH-1:0] abs_v        [NUM_CHN];
  logic [DATA_WIDTH-1:0] mag          [NUM_CHN];

  logic [2:0]         sync_q;
  logic               align_edge;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               boundary;
  logic [NUM_CHN-1:0] pwm_on;
  logic [NUM_CHN-1:0] in1_d;
  logic [NUM_CHN-1:0] in2_d;
  logic [NUM_CHN-1:0] in1_q;
  logic [NUM_CHN-1:0] in2_q;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] holds the previous synchronised level.
  assign align_edge = sync_q[1] & ~sync_q[2];

  always_comb begin
    cnt_next = cnt + CNT_W'(1);
    if (align_edge || cnt == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  assign boundary = (cnt_next == '0);

  // A word captured on the boundary cycle is the one handed to the active set.
  always_comb begin
    for (int k = 0; k < NUM_CHN; k++) begin
      pending_next[k] = pending[k];
      if (u_valid_o && u_chn_o == CHN_WIDTH'(k)) begin
        pending_next[k] = u_data_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
      cnt    <= '0;
      for (int k = 0; k < NUM_CHN; k++) begin
        pending[k] <= '0;
        active[k]  <= '0;
      end
    end else begin
      sync_q <= {sync_q[1:0], clk_pwm};
      cnt    <= cnt_next;
      for (int k = 0; k < NUM_CHN; k++) begin
        pending[k] <= pending_next[k];
        if (boundary) begin
          active[k] <= pending_next[k];
        end
      end
    end
  end

  // Two's-complement magnitude: the most negative word maps to 2^(DATA_WIDTH-1) unsigned.
  always_comb begin
    for (int k = 0; k < NUM_CHN; k++) begin
      abs_v[k]  = active[k][DATA_WIDTH-1] ? (~active[k] + DATA_WIDTH'(1)) : active[k];
      mag[k]    = (abs_v[k] > RPM_MAX_W) ? RPM_MAX_W : abs_v[k];
      pwm_on[k] = (32'(mag[k]) * 32'(PWM_PERIOD)) > (32'(cnt) * 32'(RPM_MAX));
      in1_d[k]  = pwm_on[k] && !active[k][DATA_WIDTH-1] && (active[k] != '0);
      in2_d[k]  = pwm_on[k] && active[k][DATA_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in1_q <= '0;
      in2_q <= '0;
    end else begin
      in1_q <= in1_d;
      in2_q <= in2_d;
    end
  end

  assign motor_0_in_1 = in1_q[0];
  assign motor_0_in_2 = in2_q[0];
  assign motor_1_in_1 = in1_q[1];
  assign motor_1_in_2 = in2_q[1];
  assign motor_2_in_1 = in1_q[2];
  assign motor_2_in_2 = in2_q[2];
  assign motor_3_in_1 = in1_q[3];
  assign motor_3_in_2 = in2_q[3];

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Bench for pid_pwm_driver: a behavioural model predicts per-period high-cycle counts per pin,
// and a monitor counts what the pins actually do over each PWM period.
module tb_pid_pwm_driver;

  localparam int PERIOD  = 270;
  localparam int RPM_MAX = 1500;
  localparam int NCH     = 4;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic        clk_pwm   = 1'b0;
  logic        u_valid_o = 1'b0;
  logic [2:0]  u_chn_o   = '0;
  logic [15:0] u_data_o  = '0;
  logic [3:0]  in1;
  logic [3:0]  in2;

  always #5 clk = ~clk;

  pid_pwm_driver dut (
    .clk          (clk),
    .rstn         (rstn),
    .clk_pwm      (clk_pwm),
    .u_valid_o    (u_valid_o),
    .u_chn_o      (u_chn_o),
    .u_data_o     (u_data_o),
    .motor_0_in_1 (in1[0]),
    .motor_0_in_2 (in2[0]),
    .motor_1_in_1 (in1[1]),
    .motor_1_in_2 (in2[1]),
    .motor_2_in_1 (in1[2]),
    .motor_2_in_2 (in2[2]),
    .motor_3_in_1 (in1[3]),
    .motor_3_in_2 (in2[3])
  );

  int checks = 0;
  int passes = 0;
  logic [71:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // High cycles per period: ceil(|cmd| clipped to RPM_MAX * PERIOD / RPM_MAX).
  function automatic int duty(input int a);
    int m;
    m = (a < 0) ? -a : a;
    if (m > RPM_MAX) m = RPM_MAX;
    return (m * PERIOD + RPM_MAX - 1) / RPM_MAX;
  endfunction

  // ---------------- behavioural model (state after each clk edge) ----------------
  int m_pos;
  int m_pend[NCH];
  int m_act[NCH];
  bit pwm_hist[$] = '{1'b0, 1'b0, 1'b0};
  bit realign;
  bit pin_live = 1'b0;
  int pin_pos;
  int pin_act[NCH];

  always @(posedge clk) begin
    // Pins after this edge show the period position and command held before it.
    pin_live = rstn;
    pin_pos  = m_pos;
    pin_act  = m_act;
    if (!rstn) begin
      m_pos    = 0;
      m_pend   = '{default: 0};
      m_act    = '{default: 0};
      pwm_hist = '{1'b0, 1'b0, 1'b0};
    end else begin
      if (u_valid_o && u_chn_o < 3'd4) m_pend[u_chn_o] = int'($signed(u_data_o));
      realign = pwm_hist[1] && !pwm_hist[2];
      pwm_hist.push_front(clk_pwm);
      void'(pwm_hist.pop_back());
      m_pos = realign ? 0 : (m_pos + 1) % PERIOD;
      if (m_pos == 0) m_act = m_pend;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit win_open = 1'b0;
  int win_len;
  int c1[NCH];
  int c2[NCH];
  int both;
  logic [71:0] e;

  task automatic close_window();
    logic [71:0] x;
    int d1, d2;
    x = exp_q.pop_front();
    for (int k = 0; k < NCH; k++) begin
      d1 = int'(x[k*18 +: 9]);
      d2 = int'(x[k*18+9 +: 9]);
      check($sformatf("ch%0d_in1_high", k), c1[k], (d1 < win_len) ? d1 : win_len);
      check($sformatf("ch%0d_in2_high", k), c2[k], (d2 < win_len) ? d2 : win_len);
    end
    check("both_high_cycles", both, 0);
  endtask

  always @(negedge clk) begin
    if (!pin_live) begin
      if (win_open) begin
        void'(exp_q.pop_front());
        win_open = 1'b0;
      end
      check("reset_pins", int'({in2, in1}), 0);
    end else begin
      if (pin_pos == 0) begin
        if (win_open) close_window();
        e = '0;
        for (int k = 0; k < NCH; k++) begin
          e[k*18 +: 9]   = 9'((pin_act[k] > 0) ? duty(pin_act[k]) : 0);
          e[k*18+9 +: 9] = 9'((pin_act[k] < 0) ? duty(pin_act[k]) : 0);
          c1[k] = 0;
          c2[k] = 0;
        end
        exp_q.push_back(e);
        win_len  = 0;
        both     = 0;
        win_open = 1'b1;
      end
      if (win_open) begin
        win_len++;
        for (int k = 0; k < NCH; k++) begin
          c1[k] += int'(in1[k]);
          c2[k] += int'(in2[k]);
          if (in1[k] && in2[k]) both++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int chn, input int data);
    u_valid_o = 1'b1;
    u_chn_o   = 3'(chn);
    u_data_o  = 16'(data);
    @(posedge clk);
    #1;
  endtask

  task automatic release_bus();
    u_valid_o = 1'b0;
  endtask

  task automatic burst(input int d0, input int d1, input int d2, input int d3);
    send(0, d0);
    send(1, d1);
    send(2, d2);
    send(3, d3);
    release_bus();
  endtask

  task automatic wait_pos(input int target);
    for (int i = 0; i < 2 * PERIOD && m_pos != target; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_words(input int n);
    int sel, d;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: d = int'($urandom_range(0, 65535));
        1: d = int'($urandom_range(0, 3200)) - 1600;
        2: d = 0;
        default: d = (($urandom_range(0, 1) == 1) ? -32768 : 1500);
      endcase
      send(int'($urandom_range(0, 7)), d);
      release_bus();
      cycles(int'($urandom_range(0, 120)));
    end
  endtask

  task automatic pwm_edges(input int offset, input int n);
    cycles(offset);
    for (int i = 0; i < n; i++) begin
      clk_pwm = 1'b1;
      cycles(PERIOD / 2);
      clk_pwm = 1'b0;
      cycles(PERIOD - PERIOD / 2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0;
    cycles(3);
    rstn = 1'b1;
    cycles(3 * PERIOD);

    cycles(50);
    burst(150, 500, 700, 1000);
    cycles(2 * PERIOD);

    wait_pos(120);
    burst(155, 505, 705, 1005);
    cycles(2 * PERIOD);

    burst(-155, -505, -705, -1005);
    cycles(2 * PERIOD);

    send(0, 2000);
    send(1, 0);
    send(2, -32768);
    send(5, 123);
    release_bus();
    cycles(2 * PERIOD);

    // Capture lands on the boundary edge itself.
    wait_pos(PERIOD - 1);
    send(3, -1499);
    release_bus();
    cycles(2 * PERIOD);

    random_words(40);
    cycles(2 * PERIOD);

    fork
      pwm_edges(97, 8);
      random_words(12);
    join
    cycles(2 * PERIOD);

    burst(300, -800, 1500, -1);
    wait_pos(100);
    rstn = 1'b0;
    cycles(1);
    rstn = 1'b1;
    cycles(2);
    burst(1, -1, 1499, -1501);
    cycles(3 * PERIOD);

    if (checks < 12) check("min_checks", checks, 12);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
